// File: rtl/er_start_seq_if.sv
// Control/engine-side signal bundle of the Earthrise start sequencer.
// The sequencer connects through the slave modport.
interface er_start_seq_if #(
    parameter int unsigned CH   = 2,
    parameter int unsigned CNTW = 8
);
    logic            en;
    logic [1:0]      mode;
    logic            frame;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   start;
    logic            active;
    logic            seq_done;
    logic            ack_err;
    logic [CNTW-1:0] launches;
    logic [CNTW-1:0] missed;

    modport master (
        output en, mode, frame, busy,
        input  start, active, seq_done, ack_err, launches, missed
    );

    modport slave (
        input  en, mode, frame, busy,
        output start, active, seq_done, ack_err, launches, missed
    );
endinterface

// File: rtl/er_start_seq.sv
// Earthrise start sequencer: after a reset hold-off, launches CH engines one after another on
// each trigger (once / every frame / every FRAME_DIV-th frame), counting launches and drops.
module er_start_seq #(
    parameter int unsigned CH        = 2,
    parameter int unsigned HOLD      = 16,
    parameter int unsigned FRAME_DIV = 2,
    parameter int unsigned ACK_TMO   = 8,
    parameter int unsigned CNTW      = 8
) (
    input logic           clk_sys_i,
    input logic           rst_sys_ni,
    er_start_seq_if.slave bus_if
);
    localparam int unsigned ChW     = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned HoldW   = $clog2(HOLD + 1);
    localparam int unsigned DivW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned TmoW    = $clog2(ACK_TMO + 1);
    // Last WAIT_ACK count before timing out, so ack_err lands ACK_TMO cycles after start.
    localparam int unsigned TmoLast = (ACK_TMO >= 2) ? ACK_TMO - 2 : 0;

    typedef enum logic [2:0] {
        StHold, StArm, StStart, StWaitAck, StWaitDone, StNext
    } state_e;

    state_e            state_q, state_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [DivW-1:0]   div_q, div_d;
    logic              once_q, once_d;
    logic [ChW-1:0]    ch_q, ch_d;
    logic [TmoW-1:0]   tmo_q, tmo_d;
    logic              ack_err_q, ack_err_d;
    logic [CNTW-1:0]   launches_q, launches_d;
    logic [CNTW-1:0]   missed_q, missed_d;

    logic div_wrap, frame_hit, trig, busy_sel, last_ch, is_active;

    assign div_wrap  = (div_q == DivW'(FRAME_DIV - 1));
    // A frame that would start a sequence if the sequencer were idle.
    assign frame_hit = bus_if.en & bus_if.frame &
                       ((bus_if.mode == 2'd2) | ((bus_if.mode == 2'd3) & div_wrap));
    assign trig      = (bus_if.en & (bus_if.mode == 2'd1) & ~once_q) | frame_hit;
    assign busy_sel  = bus_if.busy[ch_q];
    assign last_ch   = (ch_q == ChW'(CH - 1));
    assign is_active = (state_q == StStart) | (state_q == StWaitAck) |
                       (state_q == StWaitDone) | (state_q == StNext);

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            state_q    <= StHold;
            hold_q     <= '0;
            div_q      <= '0;
            once_q     <= 1'b0;
            ch_q       <= '0;
            tmo_q      <= '0;
            ack_err_q  <= 1'b0;
            launches_q <= '0;
            missed_q   <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            div_q      <= div_d;
            once_q     <= once_d;
            ch_q       <= ch_d;
            tmo_q      <= tmo_d;
            ack_err_q  <= ack_err_d;
            launches_q <= launches_d;
            missed_q   <= missed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        once_d    = once_q;
        ch_d      = ch_q;
        tmo_d     = tmo_q;
        ack_err_d = ack_err_q;
        unique case (state_q)
            StHold: begin
                if (hold_q == HoldW'(HOLD - 1)) state_d = StArm;
                else                            hold_d  = hold_q + HoldW'(1);
            end
            StArm: begin
                if (trig) begin
                    ch_d    = '0;
                    state_d = StStart;
                    if (bus_if.mode == 2'd1) once_d = 1'b1;
                end
            end
            StStart: begin
                tmo_d   = '0;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (busy_sel) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TmoW'(TmoLast)) begin
                    ack_err_d = 1'b1;
                    state_d   = StNext;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StWaitDone: begin
                if (!busy_sel) state_d = StNext;
            end
            StNext: begin
                if (last_ch) begin
                    state_d = StArm;
                end else begin
                    ch_d    = ch_q + ChW'(1);
                    state_d = StStart;
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_comb begin
        div_d      = div_q;
        launches_d = launches_q;
        missed_d   = missed_q;
        if (bus_if.frame) div_d = div_wrap ? '0 : div_q + DivW'(1);
        if ((state_q == StNext) && last_ch && (launches_q != '1)) launches_d = launches_q + 1'b1;
        if (is_active && frame_hit && (missed_q != '1)) missed_d = missed_q + 1'b1;
    end

    always_comb begin
        bus_if.start = '0;
        if (state_q == StStart) bus_if.start[ch_q] = 1'b1;
        bus_if.active   = is_active;
        bus_if.seq_done = (state_q == StNext) & last_ch;
        bus_if.ack_err  = ack_err_q;
        bus_if.launches = launches_q;
        bus_if.missed   = missed_q;
    end
endmodule

// File: tb/tb_er_start_seq.sv
// Bench for er_start_seq: a timeline model plans every sequence from the engine timings it
// chooses, drives busy from that plan and predicts all outputs cycle by cycle.
module tb_er_start_seq;
    localparam int unsigned CH   = 2;
    localparam int unsigned HOLD = 16;
    localparam int unsigned FD   = 2;
    localparam int unsigned TMO  = 8;
    localparam int unsigned CNTW = 4;
    localparam int          MAXC = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    er_start_seq_if #(.CH(CH), .CNTW(CNTW)) bus_if ();

    er_start_seq #(
        .CH(CH), .HOLD(HOLD), .FRAME_DIV(FD), .ACK_TMO(TMO), .CNTW(CNTW)
    ) dut (
        .clk_sys_i (clk),
        .rst_sys_ni(rst_n),
        .bus_if    (bus_if)
    );

    typedef struct {
        int mode; int en; int f0; int per; int nfr;
        int a0; int l0; int a1; int l1; int cycles;
        int exp_launch; int exp_missed; int exp_ackc; int exp_s0;
    } vec_t;

    int total = 0;
    int bad = 0;

    // Stimulus and model state; cycle n is the interval after the n-th edge since reset release.
    int   cyc;
    logic cur_en;
    logic [1:0] cur_mode;
    logic cur_frame;
    bit   rand_eng, noise_on;
    int   eng_a[CH], eng_l[CH];
    int   st[CH], nx[CH], bs[CH], be[CH];
    bit   to[CH];
    int   ack_m, launch_m, miss_m, frames_m;
    bit   once_m;
    int   first_s0, ack_first, n_s1, n_done;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; ack_m = 0; launch_m = 0; miss_m = 0; frames_m = 0; once_m = 0;
        first_s0 = -1; ack_first = -1; n_s1 = 0; n_done = 0;
        for (int c = 0; c < CH; c++) begin
            st[c] = -1; nx[c] = -1; bs[c] = -1; be[c] = -1; to[c] = 0;
        end
    endtask

    // Lay out one whole sequence: channel c starts the cycle after channel c-1 hits NEXT.
    task automatic plan(int s0);
        int s = s0;
        for (int c = 0; c < CH; c++) begin
            int a = eng_a[c];
            int l = eng_l[c];
            if (rand_eng) begin
                a = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, TMO - 1));
                l = ($urandom % 10 == 0) ? int'($urandom_range(20, 60))
                                         : int'($urandom_range(1, 6));
            end
            st[c] = s;
            if (a == 0) begin
                to[c] = 1; bs[c] = -1; be[c] = -1; nx[c] = s + TMO;
            end else begin
                to[c] = 0; bs[c] = s + a; be[c] = s + a + l; nx[c] = be[c] + 1;
            end
            s = nx[c] + 1;
        end
    endtask

    function automatic logic [CH-1:0] plan_busy();
        logic [CH-1:0] b;
        b = '0;
        for (int c = 0; c < CH; c++) begin
            if (cyc >= bs[c] && cyc < be[c]) b[c] = 1'b1;
            else if (noise_on && !(cyc >= st[c] && cyc <= nx[c]) && ($urandom % 3 == 0))
                b[c] = 1'b1;
        end
        return b;
    endfunction

    task automatic model_update();
        int div = frames_m % FD;
        bit fire = cur_en && cur_frame && (cur_mode == 2 || (cur_mode == 3 && div == FD - 1));
        bit in_seq = (cyc >= st[0]) && (cyc <= nx[CH-1]);
        if (in_seq && fire && miss_m < MAXC) miss_m++;
        for (int c = 0; c < CH; c++) if (to[c] && nx[c] == cyc + 1) ack_m = 1;
        if (in_seq && cyc == nx[CH-1]) begin
            if (launch_m < MAXC) launch_m++;
        end else if (!in_seq && cyc >= HOLD &&
                     (fire || (cur_en && cur_mode == 1 && !once_m))) begin
            if (cur_mode == 1) once_m = 1;
            plan(cyc + 1);
        end
        frames_m += int'(cur_frame);
    endtask

    task automatic check_outputs();
        logic [CH-1:0] exp_start;
        exp_start = '0;
        for (int c = 0; c < CH; c++) if (cyc == st[c]) exp_start[c] = 1'b1;
        check("start", int'(bus_if.start), int'(exp_start));
        check("active", int'(bus_if.active), (cyc >= st[0] && cyc <= nx[CH-1]) ? 1 : 0);
        check("seq_done", int'(bus_if.seq_done), (cyc == nx[CH-1]) ? 1 : 0);
        check("ack_err", int'(bus_if.ack_err), ack_m);
        check("launches", int'(bus_if.launches), launch_m);
        check("missed", int'(bus_if.missed), miss_m);
        if (bus_if.start[0] && first_s0 < 0) first_s0 = cyc;
        if (bus_if.start[1]) n_s1++;
        if (bus_if.seq_done) n_done++;
        if (bus_if.ack_err && ack_first < 0) ack_first = cyc;
    endtask

    task automatic tick();
        bus_if.en    = cur_en;
        bus_if.mode  = cur_mode;
        bus_if.frame = cur_frame;
        bus_if.busy  = plan_busy();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic do_reset();
        cur_en = 0; cur_mode = 0; cur_frame = 0;
        bus_if.en = 0; bus_if.mode = 0; bus_if.frame = 0; bus_if.busy = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        check_outputs();
    endtask

    task automatic set_eng(int a0, int l0, int a1, int l1);
        eng_a[0] = a0; eng_l[0] = l0; eng_a[1] = a1; eng_l[1] = l1;
    endtask

    task automatic cut_and_check(string tag);
        #2 rst_n = 0;
        #1;
        check({tag, "_start"}, int'(bus_if.start), 0);
        check({tag, "_active"}, int'(bus_if.active), 0);
        check({tag, "_seq_done"}, int'(bus_if.seq_done), 0);
        check({tag, "_ack_err"}, int'(bus_if.ack_err), 0);
        check({tag, "_launches"}, int'(bus_if.launches), 0);
        check({tag, "_missed"}, int'(bus_if.missed), 0);
    endtask

    vec_t vecs[9];

    initial begin
        //          mode en f0  per nfr a0 l0 a1 l1   cyc  launch missed ackc s0
        vecs[0] = '{1, 1, 20, 100, 3, 1, 5, 1, 5,   320, 1, 0, -1, 17};
        vecs[1] = '{2, 1, 20, 100, 4, 1, 3, 1, 3,   420, 4, 0, -1, 21};
        vecs[2] = '{3, 1, 20, 100, 6, 1, 3, 1, 3,   620, 3, 0, -1, 121};
        vecs[3] = '{2, 1, 20, 100, 3, 1, 5, 1, 150, 420, 2, 1, -1, 21};
        vecs[4] = '{1, 1, 0,  1,   0, 0, 1, 2, 4,   80,  1, 0, 25, 17};
        vecs[5] = '{2, 0, 20, 10,  8, 1, 3, 1, 3,   120, 0, 0, -1, -1};
        vecs[6] = '{0, 1, 20, 10,  8, 1, 3, 1, 3,   120, 0, 0, -1, -1};
        vecs[7] = '{2, 1, 20, 12,  3, 1, 3, 1, 3,   100, 2, 1, -1, 21};
        vecs[8] = '{2, 1, 20, 13,  3, 1, 3, 1, 3,   100, 3, 0, -1, 21};

        rand_eng = 0;
        noise_on = 0;
        for (int i = 0; i < 9; i++) begin
            do_reset();
            set_eng(vecs[i].a0, vecs[i].l0, vecs[i].a1, vecs[i].l1);
            cur_mode = 2'(vecs[i].mode);
            cur_en   = (vecs[i].en != 0);
            while (cyc < vecs[i].cycles) begin
                cur_frame = (vecs[i].nfr > 0) && (cyc >= vecs[i].f0) &&
                            ((cyc - vecs[i].f0) % vecs[i].per == 0) &&
                            ((cyc - vecs[i].f0) / vecs[i].per < vecs[i].nfr);
                tick();
            end
            check($sformatf("v%0d_launches", i), int'(bus_if.launches), vecs[i].exp_launch);
            check($sformatf("v%0d_missed", i), int'(bus_if.missed), vecs[i].exp_missed);
            check($sformatf("v%0d_seq_done_cnt", i), n_done, vecs[i].exp_launch);
            check($sformatf("v%0d_start1_cnt", i), n_s1, vecs[i].exp_launch);
            check($sformatf("v%0d_first_start0", i), first_s0, vecs[i].exp_s0);
            check($sformatf("v%0d_first_ack_err", i), ack_first, vecs[i].exp_ackc);
        end

        // Reset while channel 0 of the second sequence is in WAIT_DONE.
        do_reset();
        set_eng(1, 3, 1, 3);
        cur_mode = 2; cur_en = 1;
        while (cyc < 66) begin
            cur_frame = (cyc == 20) || (cyc == 60);
            if (cyc == 40) set_eng(1, 30, 1, 30);
            tick();
        end
        check("pre_reset_launches", int'(bus_if.launches), 1);
        check("pre_reset_active", int'(bus_if.active), 1);
        cut_and_check("rst_wait_done");
        @(negedge clk);
        rst_n = 1;
        model_reset();
        check_outputs();
        set_eng(1, 3, 1, 3);
        cur_mode = 1; cur_en = 1; cur_frame = 0;
        repeat (40) tick();
        check("rerun_first_start0", first_s0, HOLD + 1);
        check("rerun_launches", int'(bus_if.launches), 1);

        // Reset landing on a start pulse.
        do_reset();
        cur_mode = 1; cur_en = 1;
        while (cyc < HOLD + 1) tick();
        check("inflight_start_before", int'(bus_if.start), 1);
        cut_and_check("rst_start");
        @(negedge clk);
        rst_n = 1;

        // Randomised traffic with noisy idle channels.
        do_reset();
        rand_eng = 1;
        noise_on = 1;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom % 6)
                    0, 2: cur_mode = 2;
                    1, 3: cur_mode = 3;
                    4: cur_mode = 1;
                    default: cur_mode = 0;
                endcase
            end
            cur_en    = ($urandom % 10) != 0;
            cur_frame = ($urandom % 20) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
